// File: rtl/id_stage_if.sv
// Bundles the IF/ID, write-back and ID/EX signals of the decode stage.
// master = pipeline side driving IF/ID and WB; slave = the decode stage.
interface id_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RA_W = $clog2(NREGS);

  logic            halted;
  logic            flush;
  logic            if_id_valid;
  logic [31:0]     if_id_ir;
  logic [XLEN-1:0] if_id_npc;
  logic            id_ready;
  logic            wb_reg_write;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_a;
  logic [XLEN-1:0] id_ex_b;
  logic [XLEN-1:0] id_ex_imm;
  logic [XLEN-1:0] id_ex_npc;
  logic [31:0]     id_ex_ir;
  logic [2:0]      id_ex_type;
  logic [RA_W-1:0] id_ex_rd;
  logic            id_ex_reg_write;
  logic            illegal_op;

  modport master (
    output halted, flush, if_id_valid, if_id_ir, if_id_npc,
           wb_reg_write, wb_rd, wb_data,
    input  id_ready, id_ex_valid, id_ex_a, id_ex_b, id_ex_imm, id_ex_npc,
           id_ex_ir, id_ex_type, id_ex_rd, id_ex_reg_write, illegal_op
  );

  modport slave (
    input  halted, flush, if_id_valid, if_id_ir, if_id_npc,
           wb_reg_write, wb_rd, wb_data,
    output id_ready, id_ex_valid, id_ex_a, id_ex_b, id_ex_imm, id_ex_npc,
           id_ex_ir, id_ex_type, id_ex_rd, id_ex_reg_write, illegal_op
  );
endinterface

// File: rtl/id_stage_param.sv
// MIPS32 decode stage: regfile, load-use bubble, flush, ID/EX register.
// Optional ID_WB_BYPASS_EN: same-cycle WB data is written through to the operands.
module id_stage_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic      clk,
  input logic      rst_n,
  id_stage_if.slave bus
);
  localparam int RA_W = $clog2(NREGS);

  typedef enum logic [2:0] {
    T_RR     = 3'b000,
    T_RM     = 3'b001,
    T_LOAD   = 3'b010,
    T_STORE  = 3'b011,
    T_BRANCH = 3'b100,
    T_HALT   = 3'b101,
    T_NOP    = 3'b110
  } id_type_e;

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_npc;
  logic [31:0]     r_ir;
  id_type_e        r_type;
  logic [RA_W-1:0] r_rd;
  logic            r_reg_write;
  logic            r_illegal;

  logic [5:0]      w_opcode;
  logic [RA_W-1:0] w_rs;
  logic [RA_W-1:0] w_rt;
  logic [RA_W-1:0] w_rd_field;
  id_type_e        w_type;
  logic            w_illegal;
  logic            w_uses_rs;
  logic            w_uses_rt;
  logic [RA_W-1:0] w_dest;
  logic            w_has_dest;
  logic            w_reg_write;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_imm;
  logic            w_hazard;
  logic            w_take;

  assign w_opcode   = bus.if_id_ir[31:26];
  assign w_rs       = bus.if_id_ir[21 +: RA_W];
  assign w_rt       = bus.if_id_ir[16 +: RA_W];
  assign w_rd_field = bus.if_id_ir[11 +: RA_W];
  assign w_imm      = XLEN'($signed(bus.if_id_ir[15:0]));

  always_comb begin
    w_type     = T_HALT;
    w_illegal  = 1'b0;
    w_uses_rs  = 1'b0;
    w_uses_rt  = 1'b0;
    w_dest     = '0;
    w_has_dest = 1'b0;
    case (w_opcode)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100, 6'b000101: begin
        w_type     = T_RR;
        w_uses_rs  = 1'b1;
        w_uses_rt  = 1'b1;
        w_dest     = w_rd_field;
        w_has_dest = 1'b1;
      end
      6'b001010, 6'b001011, 6'b001100: begin
        w_type     = T_RM;
        w_uses_rs  = 1'b1;
        w_dest     = w_rt;
        w_has_dest = 1'b1;
      end
      6'b001000: begin
        w_type     = T_LOAD;
        w_uses_rs  = 1'b1;
        w_dest     = w_rt;
        w_has_dest = 1'b1;
      end
      6'b001001: begin
        w_type    = T_STORE;
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
      end
      6'b001101, 6'b001110: begin
        w_type    = T_BRANCH;
        w_uses_rs = 1'b1;
      end
      6'b111111: w_type = T_HALT;
      default: begin
        w_type    = T_HALT;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_reg_write = w_has_dest && (w_dest != '0);

  always_comb begin
    w_a = (w_rs == '0) ? '0 : r_regs[w_rs];
    w_b = (w_rt == '0) ? '0 : r_regs[w_rt];
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == w_rs)) w_a = bus.wb_data;
    if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == w_rt)) w_b = bus.wb_data;
`endif
  end

  // Only a LOAD sitting in ID/EX can stall; the bubble it inserts clears the condition next cycle.
  assign w_hazard = r_valid && (r_type == T_LOAD) && r_reg_write && bus.if_id_valid &&
                    ((w_uses_rs && (r_rd == w_rs)) || (w_uses_rt && (r_rd == w_rt)));

  assign w_take       = !bus.halted && !bus.flush && !w_hazard && bus.if_id_valid;
  assign bus.id_ready = !bus.halted && (bus.flush || !w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_reg_write && (bus.wb_rd != '0)) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_npc       <= '0;
      r_ir        <= '0;
      r_type      <= T_NOP;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!bus.halted) begin
      if (w_take) begin
        r_valid     <= 1'b1;
        r_a         <= w_a;
        r_b         <= w_b;
        r_imm       <= w_imm;
        r_npc       <= bus.if_id_npc;
        r_ir        <= bus.if_id_ir;
        r_type      <= w_type;
        r_rd        <= w_dest;
        r_reg_write <= w_reg_write;
        if (w_illegal) r_illegal <= 1'b1;
      end else begin
        r_valid     <= 1'b0;
        r_a         <= '0;
        r_b         <= '0;
        r_imm       <= '0;
        r_npc       <= '0;
        r_ir        <= '0;
        r_type      <= T_NOP;
        r_rd        <= '0;
        r_reg_write <= 1'b0;
      end
    end
  end

  assign bus.id_ex_valid     = r_valid;
  assign bus.id_ex_a         = r_a;
  assign bus.id_ex_b         = r_b;
  assign bus.id_ex_imm       = r_imm;
  assign bus.id_ex_npc       = r_npc;
  assign bus.id_ex_ir        = r_ir;
  assign bus.id_ex_type      = r_type;
  assign bus.id_ex_rd        = r_rd;
  assign bus.id_ex_reg_write = r_reg_write;
  assign bus.illegal_op      = r_illegal;
endmodule

// File: tb/tb_id_stage_param.sv
// Directed plan steps plus random traffic, checked against a behavioural decode-stage model.
module tb_id_stage_param;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  id_stage_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_a, m_b, m_imm, m_npc, m_ir;
  logic [2:0]  m_type;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_npc = 0; m_ir = 0;
    m_type = 3'b110; m_rd = 0; m_rw = 0; m_ill = 0;
  endtask

  function automatic logic [31:0] read_reg(input logic [4:0] r);
    if (r == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
`endif
    return m_regs[r];
  endfunction

  // Instruction classes straight from the opcode table.
  task automatic classify(input logic [31:0] ir, output logic [2:0] t, output logic ill,
                          output logic use_rs, output logic use_rt, output logic [4:0] dest);
    logic [5:0] op;
    op = ir[31:26];
    ill = 0; use_rs = 0; use_rt = 0; dest = 0;
    if (op <= 6'd5) begin t = 3'b000; use_rs = 1; use_rt = 1; dest = ir[15:11]; end
    else if (op >= 6'd10 && op <= 6'd12) begin t = 3'b001; use_rs = 1; dest = ir[20:16]; end
    else if (op == 6'd8) begin t = 3'b010; use_rs = 1; dest = ir[20:16]; end
    else if (op == 6'd9) begin t = 3'b011; use_rs = 1; use_rt = 1; end
    else if (op == 6'd13 || op == 6'd14) begin t = 3'b100; use_rs = 1; end
    else if (op == 6'd63) t = 3'b101;
    else begin t = 3'b101; ill = 1; end
  endtask

  // Advance the model by one clock given the inputs currently applied; returns expected id_ready.
  task automatic model_step(output logic exp_ready);
    logic [2:0] t; logic ill, urs, urt, hz; logic [4:0] dest, rs, rt;
    logic [31:0] ir;
    ir = bus.if_id_ir;
    rs = ir[25:21]; rt = ir[20:16];
    classify(ir, t, ill, urs, urt, dest);
    hz = m_valid && m_type == 3'b010 && m_rw && bus.if_id_valid &&
         ((urs && rs == m_rd) || (urt && rt == m_rd));
    exp_ready = !bus.halted && (bus.flush || !hz);
    if (!bus.halted) begin
      if (!bus.flush && !hz && bus.if_id_valid) begin
        m_valid = 1; m_a = read_reg(rs); m_b = read_reg(rt);
        m_imm = {{16{ir[15]}}, ir[15:0]}; m_npc = bus.if_id_npc; m_ir = ir;
        m_type = t; m_rd = dest; m_rw = (dest != 0); 
        if (ill) m_ill = 1;
      end else begin
        m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_npc = 0; m_ir = 0;
        m_type = 3'b110; m_rd = 0; m_rw = 0;
      end
    end
    if (bus.wb_reg_write && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.id_ex_valid), 32'(m_valid));
    chk({tag, ".a"},     bus.id_ex_a, m_a);
    chk({tag, ".b"},     bus.id_ex_b, m_b);
    chk({tag, ".imm"},   bus.id_ex_imm, m_imm);
    chk({tag, ".npc"},   bus.id_ex_npc, m_npc);
    chk({tag, ".ir"},    bus.id_ex_ir, m_ir);
    chk({tag, ".type"},  32'(bus.id_ex_type), 32'(m_type));
    chk({tag, ".rd"},    32'(bus.id_ex_rd), 32'(m_rd));
    chk({tag, ".rw"},    32'(bus.id_ex_reg_write), 32'(m_rw));
    chk({tag, ".ill"},   32'(bus.illegal_op), 32'(m_ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] npc,
                       input logic fl, input logic hl,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    bus.if_id_valid = v; bus.if_id_ir = ir; bus.if_id_npc = npc;
    bus.flush = fl; bus.halted = hl;
    bus.wb_reg_write = we; bus.wb_rd = wrd; bus.wb_data = wd;
  endtask

  task automatic cycle(input string tag);
    logic er;
    #1;
    model_step(er);
    chk({tag, ".ready"}, 32'(bus.id_ready), 32'(er));
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  logic [5:0]  ops [14];
  logic [31:0] exp_bypass;

  initial begin
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd10, 6'd11, 6'd12,
            6'd8, 6'd8, 6'd9, 6'd13, 6'd63};
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.ready", 32'(bus.id_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;

    // Plan 1: R1=5, R2=7, then ADD R3,R1,R2
    drive(0, 0, 0, 0, 0, 1, 5'd1, 32'd5);  cycle("wb_r1");
    drive(0, 0, 0, 0, 0, 1, 5'd2, 32'd7);  cycle("wb_r2");
    drive(1, 32'h00221800, 32'h104, 0, 0, 0, 0, 0); cycle("add");
    chk("t1.a", bus.id_ex_a, 32'd5);
    chk("t1.b", bus.id_ex_b, 32'd7);
    chk("t1.type", 32'(bus.id_ex_type), 32'd0);
    chk("t1.rd", 32'(bus.id_ex_rd), 32'd3);
    chk("t1.valid", 32'(bus.id_ex_valid), 32'd1);

    // Plan 2: LW R4,0(R1) then ADD R5,R4,R2 -> one bubble
    drive(1, 32'h20240000, 32'h108, 0, 0, 0, 0, 0); cycle("lw");
    drive(1, 32'h00822800, 32'h10C, 0, 0, 0, 0, 0);
    #1 chk("t2.stall_ready", 32'(bus.id_ready), 32'd0);
    cycle("bubble");
    chk("t2.bubble_type", 32'(bus.id_ex_type), 32'd6);
    chk("t2.bubble_valid", 32'(bus.id_ex_valid), 32'd0);
    cycle("add_after");
    chk("t2.add_type", 32'(bus.id_ex_type), 32'd0);
    chk("t2.add_rd", 32'(bus.id_ex_rd), 32'd5);

    // Plan 3: flush with SUBI R8,R1,#3 in IF/ID
    drive(1, 32'h2C280003, 32'h110, 1, 0, 0, 0, 0);
    #1 chk("t3.ready", 32'(bus.id_ready), 32'd1);
    cycle("flush");
    chk("t3.type", 32'(bus.id_ex_type), 32'd6);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("post_flush");
    chk("t3.no_subi", bus.id_ex_ir, 32'h0);

    // Plan 4: read R6 while WB writes it
    drive(0, 0, 0, 0, 0, 1, 5'd6, 32'h11); cycle("wb_r6_old");
    drive(1, 32'h00C03800, 32'h114, 0, 0, 1, 5'd6, 32'hDEADBEEF); cycle("same_cycle_wb");
`ifdef ID_WB_BYPASS_EN
    exp_bypass = 32'hDEADBEEF;
`else
    exp_bypass = 32'h11;
`endif
    chk("t4.a", bus.id_ex_a, exp_bypass);

    // Plan 6: halted with a valid instruction pending; WB R9=3 still lands
    drive(1, 32'h01205000, 32'h118, 0, 1, 1, 5'd9, 32'd3);
    #1 chk("t6.ready", 32'(bus.id_ready), 32'd0);
    cycle("halted");
    chk("t6.hold_a", bus.id_ex_a, exp_bypass);
    drive(1, 32'h01205000, 32'h118, 0, 0, 0, 0, 0); cycle("unhalt");
    chk("t6.r9", bus.id_ex_a, 32'd3);

    // Plan 5: illegal opcode is sticky; then reset mid-stall
    drive(1, 32'h54000000, 32'h11C, 0, 0, 0, 0, 0); cycle("illegal");
    chk("t5.type", 32'(bus.id_ex_type), 32'd5);
    chk("t5.ill", 32'(bus.illegal_op), 32'd1);
    drive(1, 32'h00221800, 32'h120, 0, 0, 0, 0, 0); cycle("legal_after");
    chk("t5.sticky", 32'(bus.illegal_op), 32'd1);
    drive(1, 32'h20240000, 32'h124, 0, 0, 0, 0, 0); cycle("lw2");
    drive(1, 32'h00822800, 32'h128, 0, 0, 0, 0, 0);
    #1 chk("t5.stall", 32'(bus.id_ready), 32'd0);
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("t5.ready_rst", 32'(bus.id_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op; logic [4:0] rs, rt, rd; logic [31:0] ir;
      op = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 39) == 0) op = 6'($urandom_range(16, 62));
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      ir = {op, rs, rt, rd, 11'($urandom)};
      drive($urandom_range(0, 99) < 85, ir, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised instruction-decode stage for the MIPS32 pipeline.
- Holds the register file and the ID/EX pipeline register.
- Adds features the fixed-width decode stage lacks:
  - valid/ready handshake with IF
  - internal load-use hazard detection with bubble insertion
  - branch flush
  - explicit NOP type distinct from HALT
  - decoded destination/write-enable
  - sticky illegal-opcode flag
- Sits between IF/ID register and EX stage; WB writes back through it.

Parameters:
XLEN, 32, datapath and register width in bits
NREGS, 32, number of architectural registers (power of 2, 2..32); register 0 reads as zero
RA_W, $clog2(NREGS), register-address width (derived; not overridden)

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
halted  input  1  freeze: ID/EX register and illegal flag hold; regfile writes still occur
flush  input  1  branch taken in EX; discard instruction in ID
if_id_valid  input  1  IF/ID holds a valid instruction
if_id_ir  input  32  instruction word
if_id_npc  input  XLEN  next PC of instruction
id_ready  output  1  ID accepts IF/ID this cycle (0 = IF must hold)
wb_reg_write  input  1  write-back enable
wb_rd  input  RA_W  write-back register
wb_data  input  XLEN  write-back data
id_ex_valid  output  1  ID/EX holds a real instruction
id_ex_a  output  XLEN  rs operand
id_ex_b  output  XLEN  rt operand
id_ex_imm  output  XLEN  sign-extended imm[15:0]
id_ex_npc  output  XLEN  forwarded NPC
id_ex_ir  output  32  forwarded instruction
id_ex_type  output  3  RR=000 RM=001 LOAD=010 STORE=011 BRANCH=100 HALT=101 NOP=110
id_ex_rd  output  RA_W  decoded destination register
id_ex_reg_write  output  1  instruction writes id_ex_rd (0 when rd=0)
illegal_op  output  1  sticky: unknown opcode decoded

Behaviour:
- Reset (async, rst_n=0):
  - all ID/EX outputs 0, except id_ex_type=NOP
  - id_ex_valid=0, illegal_op=0
  - all registers in the regfile cleared to 0
- Opcodes:
  - ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101 -> RR
  - ADDI 001010, SUBI 001011, SLTI 001100 -> RM
  - LW 001000 -> LOAD
  - SW 001001 -> STORE
  - BNEQZ 001101, BEQZ 001110 -> BRANCH
  - HLT 111111 -> HALT
  - any other opcode -> HALT, and illegal_op set.
- Register fields: rs=IR[25:21], rt=IR[20:16], rd=IR[15:11]; each truncated to RA_W bits.
- Destination:
  - RR -> rd; RM and LOAD -> rt
  - STORE, BRANCH, HALT -> no destination (reg_write=0)
- Operand read: the ID/EX latch reads register 0 as 0.
- Regfile write: on posedge, when wb_reg_write=1 and wb_rd!=0.
- Load-use hazard is asserted when all of the following hold:
  - id_ex_valid=1, id_ex_type=LOAD, id_ex_reg_write=1
  - if_id_valid=1
  - id_ex_rd matches a used source:
    - RR, STORE: rs or rt
    - RM, LOAD, BRANCH: rs
    - HALT: none
- Per-cycle priority (when halted=0):
  1. flush=1: ID/EX <- NOP (valid=0); id_ready=1, so IF/ID content is consumed and dropped.
  2. Hazard: ID/EX <- NOP bubble; id_ready=0. Exactly one bubble, because the next cycle ID/EX holds a NOP.
  3. if_id_valid=1: latch the decode; valid=1; id_ready=1.
  4. if_id_valid=0: ID/EX <- NOP; id_ready=1.
- Halted: when halted=1, id_ready=0 and ID/EX holds. Regfile and WB path stay live.
- Latency: one cycle from IF/ID to ID/EX.
- NOP bubble values: a, b, imm, npc, ir, rd all 0; reg_write=0.
- Reset asserted mid-stall or mid-flush returns the block to the reset state immediately. No pending hazard survives reset.

Optional Feature:
Macro ID_WB_BYPASS_EN.
- Defined: if wb_reg_write=1, wb_rd!=0 and wb_rd equals a source register being read this cycle, the operand takes wb_data (write-through). Same-cycle WB/ID dependence therefore sees the new value.
- Undefined: the operand takes the old regfile content. Software must separate a producer and its consumer by at least one extra instruction.

Test Plan:
1. Reset, then WB writes R1=5, R2=7 (NREGS=32). Next, issue ADD R3,R1,R2 (0x00221800) -> one cycle later: id_ex_a=5, id_ex_b=7, type=000, rd=3, reg_write=1, valid=1.
2. Issue LW R4,0(R1), then ADD R5,R4,R2 back-to-back:
   - cycle of ADD in ID: id_ready=0; ID/EX gets NOP (type=110, valid=0).
   - following cycle: ADD is latched with id_ready=1.
3. Assert flush=1 with SUBI in IF/ID -> ID/EX type=110, valid=0, id_ready=1; SUBI never appears in EX.
4. Read R6 in the same cycle WB writes R6=0xDEADBEEF:
   - with ID_WB_BYPASS_EN: id_ex_a=0xDEADBEEF
   - without it: id_ex_a=old value.
5. Opcode 010101 -> type=101, illegal_op=1, stays 1 through later legal instructions. Pull rst_n low mid-stall -> all outputs return to reset values asynchronously.
6. halted=1 while valid ADD is pending -> ID/EX unchanged, id_ready=0; WB write of R9=3 still lands and reads back 3 after halted falls.
